// File: rtl/mux_scan.sv
// Registered N-channel W-bit multiplexer with manual select and a
// dwell-timed round-robin scanner over an enable mask.
module mux_scan #(
  parameter int W     = 8,
  parameter int N     = 4,
  parameter int SELW  = 2,
  parameter int DWELL = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N*W-1:0]  din,
  input  logic [SELW-1:0] sel,
  input  logic            mode,
  input  logic [N-1:0]    en_mask,
  input  logic            hold,
  output logic [W-1:0]    dout,
  output logic [SELW-1:0] ch,
  output logic            valid,
  output logic            wrap
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  typedef enum logic [1:0] {
    IDLE,
    MANUAL,
    SCAN
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    dout_q, dout_d;
  logic [SELW-1:0] ch_q, ch_d;
  logic            valid_q, valid_d;
  logic            wrap_q, wrap_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [SELW-1:0] low_idx;
  logic [SELW-1:0] nxt_idx;
  logic            nxt_hit;
  logic            sel_ok;
  logic            sel_en;
  logic            ch_en;

  function automatic logic [W-1:0] pick(
    input logic [N*W-1:0]  d,
    input logic [SELW-1:0] idx
  );
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) begin
      if (idx == SELW'(k)) r = d[k*W +: W];
    end
    return r;
  endfunction

  // Next channel: lowest enabled index above ch, else lowest overall
  always_comb begin
    low_idx = '0;
    nxt_idx = '0;
    nxt_hit = 1'b0;
    sel_ok  = 1'b0;
    sel_en  = 1'b0;
    ch_en   = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (en_mask[k]) begin
        low_idx = SELW'(k);
        if (k > int'(ch_q)) begin
          nxt_idx = SELW'(k);
          nxt_hit = 1'b1;
        end
      end
    end
    if (!nxt_hit) nxt_idx = low_idx;
    for (int k = 0; k < N; k++) begin
      if (sel == SELW'(k)) begin
        sel_ok = 1'b1;
        sel_en = en_mask[k];
      end
      if (ch_q == SELW'(k)) ch_en = en_mask[k];
    end
  end

  always_comb begin
    state_d = state_q;
    dout_d  = dout_q;
    ch_d    = ch_q;
    valid_d = valid_q;
    wrap_d  = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, MANUAL: begin
        if (mode) begin
          if (|en_mask) begin
            state_d = SCAN;
            ch_d    = low_idx;
            cnt_d   = '0;
            dout_d  = pick(din, low_idx);
            valid_d = 1'b1;
          end else begin
            state_d = IDLE;
            valid_d = 1'b0;
          end
        end else if (state_q == IDLE) begin
          state_d = MANUAL;
        end else begin
          ch_d = sel;
          if (sel_ok) begin
            dout_d  = pick(din, sel);
            valid_d = sel_en;
          end else begin
            valid_d = 1'b0;
          end
        end
      end
      SCAN: begin
        if (~|en_mask) begin
          state_d = IDLE;
          valid_d = 1'b0;
          cnt_d   = '0;
        end else if (!mode) begin
          state_d = MANUAL;
          cnt_d   = '0;
          dout_d  = pick(din, ch_q);
          valid_d = ch_en;
        end else begin
          valid_d = 1'b1;
          // A disabled current channel is abandoned even under hold
          if (!ch_en || (!hold && cnt_q == LAST)) begin
            ch_d   = nxt_idx;
            cnt_d  = '0;
            wrap_d = (nxt_idx <= ch_q);
          end else if (!hold) begin
            cnt_d = cnt_q + CW'(1);
          end
          dout_d = pick(din, ch_d);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dout_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout  = dout_q;
  assign ch    = ch_q;
  assign valid = valid_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_mux_scan.sv
// Scoreboard bench for mux_scan: W=8, N=4, DWELL=3.
module tb_mux_scan;

  logic        clk;
  logic        rst_n;
  logic [31:0] din;
  logic [1:0]  sel;
  logic        mode;
  logic [3:0]  en_mask;
  logic        hold;
  logic [7:0]  dout;
  logic [1:0]  ch;
  logic        valid;
  logic        wrap;

  logic [11:0] obs;
  logic [11:0] e;
  logic [11:0] sb[$];
  int          n_chk;
  int          n_pass;

  localparam logic [31:0] DIN0 = 32'h4433_2211;

  mux_scan #(
    .W(8), .N(4), .SELW(2), .DWELL(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .sel(sel),
    .mode(mode), .en_mask(en_mask), .hold(hold),
    .dout(dout), .ch(ch), .valid(valid), .wrap(wrap)
  );

  assign obs = {dout, ch, valid, wrap};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  function automatic logic [11:0] ex(
    input logic [7:0] d, input logic [1:0] c,
    input logic v, input logic w
  );
    return {d, c, v, w};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b1;
    din     = $urandom;
    sel     = 2'($urandom_range(0, 3));
    mode    = 1'($urandom_range(0, 1));
    en_mask = 4'($urandom_range(0, 15));
    hold    = 1'($urandom_range(0, 1));
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(ex(8'h00, 2'd0, 1'b0, 1'b0));
      if (i > 0) begin
        din  = $urandom;
        mode = 1'($urandom_range(0, 1));
        tick();
      end
      e = sb.pop_front();
      n_chk++;
      if (obs !== e)
        $display("FAIL reset_hold[%0d]: got %h/%0d/%b/%b want %h/%0d/%b/%b",
                 i, obs[11:4], obs[3:2], obs[1], obs[0],
                 e[11:4], e[3:2], e[1], e[0]);
      else n_pass++;
    end
    rst_n   = 1'b1;
    din     = DIN0;
    mode    = 1'b0;
    sel     = 2'd2;
    en_mask = 4'b1111;
    hold    = 1'b0;
    sb.push_back(ex(8'h00, 2'd0, 1'b0, 1'b0));
    sb.push_back(ex(8'h33, 2'd2, 1'b1, 1'b0));
    for (int i = 0; i < 2; i++) begin
      tick();
      e = sb.pop_front();
      n_chk++;
      if (obs !== e)
        $display("FAIL reset_release[%0d]: got %h/%0d/%b/%b want %h/%0d/%b/%b",
                 i, obs[11:4], obs[3:2], obs[1], obs[0],
                 e[11:4], e[3:2], e[1], e[0]);
      else n_pass++;
    end
  endtask

  task automatic test_manual();
    logic [7:0] dv [4];
    logic [3:0] vv;
    dv[0] = 8'h11; dv[1] = 8'h22; dv[2] = 8'h33; dv[3] = 8'h44;
    vv = 4'b1011;
    en_mask = 4'b1011;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      sb.push_back(ex(dv[s], 2'(s), vv[s], 1'b0));
      tick();
      e = sb.pop_front();
      n_chk++;
      if (obs !== e)
        $display("FAIL manual[%0d]: got %h/%0d/%b/%b want %h/%0d/%b/%b",
                 s, obs[11:4], obs[3:2], obs[1], obs[0],
                 e[11:4], e[3:2], e[1], e[0]);
      else n_pass++;
    end
  endtask

  task automatic test_scan();
    logic [1:0] cs [13];
    logic [7:0] dv [4];
    dv[0] = 8'h11; dv[1] = 8'h22; dv[2] = 8'h33; dv[3] = 8'h44;
    for (int i = 0; i < 13; i++) cs[i] = 2'((i / 3) % 4);
    mode    = 1'b1;
    en_mask = 4'b1111;
    for (int i = 0; i < 13; i++)
      sb.push_back(ex(dv[cs[i]], cs[i], 1'b1, i == 12));
    for (int i = 0; i < 13; i++) begin
      tick();
      e = sb.pop_front();
      n_chk++;
      if (obs !== e)
        $display("FAIL scan[%0d]: got %h/%0d/%b/%b want %h/%0d/%b/%b",
                 i, obs[11:4], obs[3:2], obs[1], obs[0],
                 e[11:4], e[3:2], e[1], e[0]);
      else n_pass++;
    end
  endtask

  task automatic test_sparse_hold();
    logic       hv [21];
    logic       dd [21];
    en_mask = 4'b1010;
    for (int i = 0; i < 12; i++) begin
      if ((i / 3) % 2 == 0) sb.push_back(ex(8'h22, 2'd1, 1'b1, i == 6));
      else                  sb.push_back(ex(8'h44, 2'd3, 1'b1, 1'b0));
    end
    sb.push_back(ex(8'h22, 2'd1, 1'b1, 1'b1));
    sb.push_back(ex(8'h22, 2'd1, 1'b1, 1'b0));
    sb.push_back(ex(8'h22, 2'd1, 1'b1, 1'b0));
    for (int i = 0; i < 4; i++) sb.push_back(ex(8'h5A, 2'd1, 1'b1, 1'b0));
    sb.push_back(ex(8'h5A, 2'd1, 1'b1, 1'b0));
    sb.push_back(ex(8'h44, 2'd3, 1'b1, 1'b0));
    for (int i = 0; i < 21; i++) begin
      hv[i] = (i >= 14 && i <= 18);
      dd[i] = (i >= 15);
    end
    for (int i = 0; i < 21; i++) begin
      hold = hv[i];
      din  = dd[i] ? {DIN0[31:16], 8'h5A, DIN0[7:0]} : DIN0;
      tick();
      e = sb.pop_front();
      n_chk++;
      if (obs !== e)
        $display("FAIL sparse_hold[%0d]: got %h/%0d/%b/%b want %h/%0d/%b/%b",
                 i, obs[11:4], obs[3:2], obs[1], obs[0],
                 e[11:4], e[3:2], e[1], e[0]);
      else n_pass++;
    end
    hold = 1'b0;
    din  = DIN0;
  endtask

  task automatic test_mask_edges();
    logic [3:0] mv [14];
    logic       dd [14];
    mv[0] = 4'b1010;
    for (int i = 1; i < 5; i++) mv[i] = 4'b0010;
    mv[5] = 4'b0000; mv[6] = 4'b0000;
    for (int i = 7; i < 14; i++) mv[i] = 4'b0100;
    for (int i = 0; i < 14; i++) dd[i] = (i == 6);
    sb.push_back(ex(8'h44, 2'd3, 1'b1, 1'b0));
    sb.push_back(ex(8'h22, 2'd1, 1'b1, 1'b1));
    sb.push_back(ex(8'h22, 2'd1, 1'b1, 1'b0));
    sb.push_back(ex(8'h22, 2'd1, 1'b1, 1'b0));
    sb.push_back(ex(8'h22, 2'd1, 1'b1, 1'b1));
    sb.push_back(ex(8'h22, 2'd1, 1'b0, 1'b0));
    sb.push_back(ex(8'h22, 2'd1, 1'b0, 1'b0));
    for (int i = 0; i < 7; i++)
      sb.push_back(ex(8'h33, 2'd2, 1'b1, i == 3 || i == 6));
    for (int i = 0; i < 14; i++) begin
      en_mask = mv[i];
      din     = dd[i] ? {DIN0[31:16], 8'h77, DIN0[7:0]} : DIN0;
      tick();
      e = sb.pop_front();
      n_chk++;
      if (obs !== e)
        $display("FAIL mask_edge[%0d]: got %h/%0d/%b/%b want %h/%0d/%b/%b",
                 i, obs[11:4], obs[3:2], obs[1], obs[0],
                 e[11:4], e[3:2], e[1], e[0]);
      else n_pass++;
    end
    din = DIN0;
  endtask

  task automatic test_async_reset();
    sb.push_back(ex(8'h33, 2'd2, 1'b1, 1'b0));
    tick();
    e = sb.pop_front();
    n_chk++;
    if (obs !== e)
      $display("FAIL pre_reset: got %h/%0d/%b/%b want %h/%0d/%b/%b",
               obs[11:4], obs[3:2], obs[1], obs[0],
               e[11:4], e[3:2], e[1], e[0]);
    else n_pass++;
    #2 rst_n = 1'b0;
    sb.push_back(ex(8'h00, 2'd0, 1'b0, 1'b0));
    #1;
    e = sb.pop_front();
    n_chk++;
    if (obs !== e)
      $display("FAIL async_clear: got %h/%0d/%b/%b want %h/%0d/%b/%b",
               obs[11:4], obs[3:2], obs[1], obs[0],
               e[11:4], e[3:2], e[1], e[0]);
    else n_pass++;
    en_mask = 4'b1110;
    #3 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) sb.push_back(ex(8'h22, 2'd1, 1'b1, 1'b0));
    sb.push_back(ex(8'h33, 2'd2, 1'b1, 1'b0));
    for (int i = 0; i < 4; i++) begin
      tick();
      e = sb.pop_front();
      n_chk++;
      if (obs !== e)
        $display("FAIL restart[%0d]: got %h/%0d/%b/%b want %h/%0d/%b/%b",
                 i, obs[11:4], obs[3:2], obs[1], obs[0],
                 e[11:4], e[3:2], e[1], e[0]);
      else n_pass++;
    end
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    test_reset();
    test_manual();
    test_scan();
    test_sparse_hold();
    test_mask_edges();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mux_scan.md
# mux_scan

Parametrised, registered N-channel multiplexer with manual-select and auto-scan modes. It generalises the 4:1 single-bit selector to W-bit channels and N inputs. A dwell-timed round-robin scanner steps through channels enabled by a mask, and a 1-cycle wrap pulse marks the end of each scan sweep. It sits between parallel data sources and a single downstream consumer, for example a display or serial logger, that samples one channel at a time.

## Interface
- W, default 8: channel data width in bits (W ≥ 1).
- N, default 4: number of input channels (N ≥ 2).
- SELW, default 2: select/channel-index width, equal to clog2(N).
- DWELL, default 15: cycles spent on each channel in scan mode (DWELL ≥ 1).

- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- din  input  N*W  packed channel data; channel k occupies din[k*W +: W].
- sel  input  SELW  manual channel select, used in manual mode only.
- mode  input  1  0 = manual, 1 = auto-scan.
- en_mask  input  N  per-channel enable; bit k enables channel k.
- hold  input  1  when 1 in scan mode, freezes the dwell counter and the channel index.
- dout  output  W  registered data of the current channel.
- ch  output  SELW  index of the channel currently driving dout.
- valid  output  1  dout carries data from an enabled channel.
- wrap  output  1  1-cycle pulse when the scan wraps to the lowest enabled channel.

## Operation
- Reset (async assert): dout=0, ch=0, valid=0, wrap=0, dwell counter=0, state=IDLE. Outputs hold these values until the first rising edge after rst_n deasserts.
- States: IDLE, MANUAL, SCAN. Each transition takes effect on the next rising edge.
- IDLE:
  - mode=0 → MANUAL.
  - mode=1 and en_mask≠0 → SCAN, with ch = lowest set bit of en_mask and counter=0.
  - mode=1 and en_mask=0 → stay in IDLE; valid=0; dout holds its value.
- MANUAL:
  - Each cycle: ch<=sel and dout<=din[sel].
  - valid<=1 iff sel<N and en_mask[sel]=1.
  - If sel≥N: dout holds its value and valid<=0.
  - wrap is always 0.
  - mode=1 → IDLE evaluation on the next edge, which enters SCAN.
- SCAN:
  - dout<=din[ch] every cycle (live tracking) and valid<=1.
  - Counter runs 0..DWELL-1. When counter=DWELL-1 and hold=0: counter<=0, and ch<=next enabled index above ch, searching circularly.
  - wrap<=1 in the same cycle that ch is updated, whenever the new index ≤ the old index. This includes the single-enabled-channel case, which pulses wrap every DWELL cycles.
  - hold=1: counter and ch are frozen; dout keeps tracking din[ch]; wrap=0.
  - en_mask[ch] cleared mid-dwell: advance to the next enabled channel on the next edge (hold is ignored) and reset the counter to 0. wrap follows the same rule as a normal advance.
  - en_mask becomes 0: → IDLE; valid<=0; dout and ch hold their values.
  - mode=0 → MANUAL on the next edge. Counter is reset.
- Arithmetic: counter width is max(1, clog2(DWELL)). The next-channel search is combinational over N bits with circular priority starting at ch+1. Index wrap-around is modulo N.

## Timing
- din → dout latency is 1 cycle in both modes.
- Change of sel → ch/dout after 1 cycle.
- In scan mode, each channel is presented for exactly DWELL cycles, excluding hold cycles. DWELL=1 advances every cycle.
- wrap is high for exactly 1 cycle, aligned with the first cycle that ch shows the wrapped index.
- Reset assertion mid-scan clears all outputs immediately, with no clock required.

## Test plan
W=8, N=4, DWELL=3, din channels = 0x11, 0x22, 0x33, 0x44.
- **Reset:** hold rst_n=0 with random inputs → dout=0x00, ch=0, valid=0, wrap=0. Release rst_n, mode=0, sel=2 → after 2 edges (IDLE→MANUAL, then first MANUAL update) dout=0x33, ch=2, valid=1.
- **Manual with mask:** mode=0, en_mask=4'b1011; sweep sel=0..3 → dout = 0x11, 0x22, 0x33, 0x44 with 1-cycle lag; valid = 1, 1, 0, 1.
- **Auto-scan:** mode=1, en_mask=4'b1111 → ch sequence 0,0,0,1,1,1,2,2,2,3,3,3,0. wrap=1 only on the cycle ch returns to 0. valid=1 throughout.
- **Sparse mask and hold:** en_mask=4'b1010 → ch alternates 1,3 every 3 cycles; wrap pulses on each 3→1 transition. Assert hold for 5 cycles mid-dwell → ch stays fixed for 5 extra cycles and the dwell then completes. Change din[ch] to 0x5A during hold → dout=0x5A 1 cycle later.
- **Mask edge cases:** clear en_mask bit of the current ch mid-dwell → ch advances next edge and the counter restarts. Set en_mask=0 → valid=0 next edge; dout and ch frozen. Restore en_mask=4'b0100 → ch=2, and wrap pulses every 3 cycles.
- **Async reset mid-scan:** pulse rst_n low between clock edges → outputs clear immediately. After release, scan restarts from the lowest enabled channel.
